// File: rtl/data_mem_responder.sv
// Handshaked byte-serial data memory for load/store requests; MISALIGN_TRAP_EN rejects misaligned H/W accesses.
// Latency: response pulse N+1 cycles after accept (N = 1/2/4 bytes), 1 cycle for rejected requests.
// Backpressure: req_ready only in IDLE; resp_valid is a single-cycle pulse with no response backpressure.
module data_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_fun3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          fun3_q, fun3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [31:0]         asm_q, asm_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [7:0]          mem_q [DEPTH];

    logic                accept;
    logic                req_legal;
    logic [1:0]          last_idx;
    logic                last_byte;
    logic [ADDR_W-1:0]   byte_addr;
    logic [7:0]          rd_byte;
    logic [7:0]          wr_byte;
    logic                mem_we;
    logic [31:0]         asm_next;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f);
        case (f)
            3'b000:  extend = {{24{v[7]}}, v[7:0]};
            3'b001:  extend = {{16{v[15]}}, v[15:0]};
            3'b100:  extend = {24'b0, v[7:0]};
            3'b101:  extend = {16'b0, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    assign accept = req_valid && (state_q == S_IDLE);

    always_comb begin
        case (req_fun3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_we;
            default:                req_legal = 1'b0;
        endcase
`ifdef MISALIGN_TRAP_EN
        if ((req_fun3[1:0] == 2'b01 && req_addr[0]) ||
            (req_fun3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
            req_legal = 1'b0;
`endif
    end

    always_comb begin
        case (fun3_q[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // Byte address wraps naturally because DEPTH == 2**ADDR_W.
    assign last_byte = (cnt_q == last_idx);
    assign byte_addr = addr_q + ADDR_W'(cnt_q);
    assign rd_byte   = mem_q[byte_addr];
    assign wr_byte   = wdata_q[{cnt_q, 3'b000} +: 8];
    assign mem_we    = (state_q == S_ACCESS) && we_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = req_legal ? S_ACCESS : S_RESP;
            S_ACCESS: if (last_byte) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    always_comb begin
        we_d     = we_q;
        fun3_d   = fun3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        asm_next = asm_q;
        asm_next[{cnt_q, 3'b000} +: 8] = rd_byte;
        if (accept) begin
            we_d    = req_we;
            fun3_d  = req_fun3;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            cnt_d   = 2'd0;
            asm_d   = 32'b0;
            if (!req_legal) begin
                rdata_d = 32'b0;
                err_d   = 1'b1;
            end
        end else if (state_q == S_ACCESS) begin
            asm_d = asm_next;
            cnt_d = cnt_q + 2'd1;
            if (last_byte) begin
                // The last lane is taken straight from the array so extension sees the full value.
                cnt_d   = 2'd0;
                err_d   = 1'b0;
                rdata_d = we_q ? 32'b0 : extend(asm_next, fun3_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            fun3_q  <= 3'b0;
            addr_q  <= '0;
            wdata_q <= 32'b0;
            cnt_q   <= 2'd0;
            asm_q   <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            fun3_q  <= fun3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; bytes already stored by an interrupted store stay written.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[byte_addr] <= wr_byte;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array reference model (honours MISALIGN_TRAP_EN).
// Latency: checks response pulse timing per request. Backpressure: one outstanding request at a time.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_fun3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_fun3   (req_fun3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    logic [7:0] mem_m [256];
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes_m(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit legal_m(input bit we, input logic [2:0] f, input logic [7:0] a);
        bit ok;
        if (we) ok = (f == 3'd0 || f == 3'd1 || f == 3'd2);
        else    ok = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
`ifdef MISALIGN_TRAP_EN
        if (ok && (int'(a) % nbytes_m(f)) != 0) ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic do_req(input string tag, input bit we, input logic [2:0] f,
                          input logic [7:0] a, input logic [31:0] wd, output logic [31:0] rd_got);
        bit          ok;
        int          nb;
        int          lat;
        logic [31:0] v;
        logic [31:0] exp_rd;
        logic [7:0]  ak;
        ok = legal_m(we, f, a);
        nb = nbytes_m(f);
        v = 32'b0;
        exp_rd = 32'b0;
        if (ok) begin
            for (int k = 0; k < nb; k++) begin
                ak = 8'(int'(a) + k);
                if (we) mem_m[ak] = wd[8*k +: 8];
                else    v = v | (32'(mem_m[ak]) << (8*k));
            end
            if (!we) begin
                exp_rd = v;
                if (f == 3'd0 && v[7])  exp_rd = v | 32'hFFFF_FF00;
                if (f == 3'd1 && v[15]) exp_rd = v | 32'hFFFF_0000;
            end
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_fun3  = f;
        req_addr  = a;
        req_wdata = wd;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        if (!req_ready) check_eq({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_fun3  = 3'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = $urandom;

        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) check_eq({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, "_lat"}, 32'(lat), ok ? 32'(nb + 1) : 32'd1);
        rd_got = resp_rdata;
        if (lat != 0) begin
            check_eq({tag, "_err"}, 32'(resp_err), ok ? 32'd0 : 32'd1);
            check_eq({tag, "_rdata"}, resp_rdata, exp_rd);
            @(negedge clk);
            check_eq({tag, "_pulse"}, 32'(resp_valid), 32'd0);
            check_eq({tag, "_hold"}, resp_rdata, exp_rd);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  old22, old23;
        int          stray;

        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_fun3  = 3'b0;
        req_addr  = 8'b0;
        req_wdata = 32'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", 32'(resp_err), 32'd0);

        // Give every byte a known value before any load.
        for (int i = 0; i < 64; i++) do_req("fill", 1'b1, 3'd2, 8'(4*i), $urandom, rd);

        do_req("sw10", 1'b1, 3'd2, 8'h10, 32'h8001_7FFE, rd);
        do_req("lw10", 1'b0, 3'd2, 8'h10, 32'h0, rd);
        check_eq("lw10_const", rd, 32'h8001_7FFE);
        do_req("lb13", 1'b0, 3'd0, 8'h13, 32'h0, rd);
        check_eq("lb13_const", rd, 32'hFFFF_FF80);
        do_req("lbu13", 1'b0, 3'd4, 8'h13, 32'h0, rd);
        check_eq("lbu13_const", rd, 32'h0000_0080);
        do_req("lh10", 1'b0, 3'd1, 8'h10, 32'h0, rd);
        check_eq("lh10_const", rd, 32'h0000_7FFE);
        do_req("lhu12", 1'b0, 3'd5, 8'h12, 32'h0, rd);
        check_eq("lhu12_const", rd, 32'h0000_8001);
        do_req("sb11", 1'b1, 3'd0, 8'h11, 32'h0000_00AA, rd);
        do_req("lw10b", 1'b0, 3'd2, 8'h10, 32'h0, rd);
        check_eq("lw10b_const", rd, 32'h8001_AAFE);

        do_req("swfe", 1'b1, 3'd2, 8'hFE, 32'h4433_2211, rd);
        do_req("lwfe", 1'b0, 3'd2, 8'hFE, 32'h0, rd);
`ifndef MISALIGN_TRAP_EN
        check_eq("lwfe_const", rd, 32'h4433_2211);
        do_req("lbu00", 1'b0, 3'd4, 8'h00, 32'h0, rd);
        check_eq("lbu00_const", rd, 32'h0000_0033);
`endif

        do_req("ill011", 1'b0, 3'd3, 8'h40, 32'h0, rd);
        check_eq("ill011_const", rd, 32'h0);
        do_req("illsb4", 1'b1, 3'd4, 8'h44, 32'hFFFF_FFFF, rd);

        // Reset after two bytes of a word store: only those two bytes change.
        old22 = mem_m[8'h22];
        old23 = mem_m[8'h23];
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_fun3  = 3'd2;
        req_addr  = 8'h20;
        req_wdata = 32'hDDCC_BBAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(req_ready), 32'd1);
        check_eq("midrst_valid", 32'(resp_valid), 32'd0);
        check_eq("midrst_rdata", resp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_m[8'h20] = 8'hAA;
        mem_m[8'h21] = 8'hBB;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        check_eq("midrst_noresp", 32'(stray), 32'd0);
        do_req("lw20", 1'b0, 3'd2, 8'h20, 32'h0, rd);
        check_eq("lw20_const", rd, {old23, old22, 16'hBBAA});

        for (int i = 0; i < 200; i++) begin
            do_req("rand", 1'($urandom), 3'($urandom), 8'($urandom), $urandom, rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's load/store memory interface: accepts one request at a time and returns one response.
- Request carries read/write, the load/store funct3 code, a byte address and write data.
- Backing store is a byte array; each request is served serially, one byte per cycle, little-endian.
- Replaces the combinational data memory where a multi-cycle, handshaked memory is needed (multi-cycle or pipelined core with stall).

Parameters:
- ADDR_W, 8, byte address width.
- DEPTH, 256, number of bytes in the backing array; must equal 2**ADDR_W.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_fun3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  ADDR_W  byte address of the lowest byte.
- req_wdata  input  32  store data; the low byte is stored first.
- resp_valid  output  1  one-cycle pulse; the response is complete.
- resp_rdata  output  32  load result, extended per funct3; held until the next response.
- resp_err  output  1  qualified by resp_valid; request was rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; byte counter=0.
  - Array contents are not reset.
- Accept: in IDLE, req_valid && req_ready at edge T latches we, fun3, addr, wdata.
- Byte count N from fun3[1:0]: 00 gives 1, 01 gives 2, 10 gives 4.
  - Load fun3 011, 110, 111 is illegal.
  - Store fun3 other than 000, 001, 010 is illegal.
- States: IDLE, ACCESS, RESP.
  - IDLE to ACCESS on accept with legal fun3.
  - IDLE to RESP on accept with illegal fun3. In that case resp_err=1, resp_rdata=0, and the array is untouched.
  - ACCESS lasts exactly N cycles. In cycle k (k=0..N-1) the byte address is (addr+k) mod DEPTH.
    - Store: writes wdata[8k+7:8k].
    - Load: captures the array byte into byte lane k of an internal assembly register.
  - ACCESS to RESP after byte N-1.
  - RESP lasts one cycle with resp_valid=1, then returns to IDLE.
- Latency: accept at edge T; resp_valid is high in the cycle after edge T+N, i.e. N+1 cycles after accept.
  - Minimum request-to-request spacing is N+2 cycles.
- Load extension, applied when entering RESP:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes all 32 bits.
- Store response: resp_rdata=0, resp_err=0.
- resp_rdata and resp_err update only on entry to RESP. Between responses they hold their last values.
- req_valid while not IDLE is ignored (req_ready=0). The request must be held by the initiator until accepted.
- No response backpressure: resp_valid is a single-cycle pulse and the initiator must sample it.
- Address wrap: accesses crossing DEPTH-1 continue at byte 0.
- Without the optional feature, misaligned accesses are legal and served bytewise.
- Read-after-write to the same byte in consecutive requests returns the new data (the array write lands before the next ACCESS read).
- Reset mid-operation: returns to IDLE immediately and no response is produced. Store bytes already written stay written (partial store permitted).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]!=00, is treated like an illegal fun3.
  - Path is IDLE to RESP with resp_err=1, resp_rdata=0, and no array write.
  - Aligned accesses are unchanged.
  - Wrap-around can then only occur at the natural boundary and never splits an access.
- Not defined: misaligned accesses are served as described in Behaviour; resp_err is driven only by illegal fun3.

Test Plan:
- Reset, then release rst -> req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0 before any request.
- SW addr=0x10 wdata=0x8001_7FFE, then LW 0x10 -> store resp_valid 5 cycles after accept; LW returns 0x8001_7FFE with resp_err=0.
- Loads against the stored word 0x8001_7FFE at 0x10:
  - LB 0x13 -> 0xFFFF_FF80; LBU 0x13 -> 0x0000_0080.
  - LH 0x10 -> 0x0000_7FFE; LHU 0x12 -> 0x0000_8001.
  - LB resp_valid arrives 2 cycles after accept.
- SB 0x11 wdata=0xAA, then LW 0x10 -> 0x8001_AAFE; only byte 0x11 changed.
- SW addr=0xFE wdata=0x4433_2211:
  - Without MISALIGN_TRAP_EN, bytes 0xFE=0x11, 0xFF=0x22, 0x00=0x33, 0x01=0x44, and LW 0xFE returns 0x4433_2211.
  - With MISALIGN_TRAP_EN, resp_err=1 and the array is unchanged.
- Illegal and interrupted requests:
  - Load fun3=011 -> resp_valid 1 cycle after accept, resp_err=1, resp_rdata=0.
  - Assert rst during ACCESS of an SW at 0x20 after 2 bytes -> no resp_valid, state IDLE, bytes 0x20-0x21 new and 0x22-0x23 old.
